// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue pipeline register in front of the 32-bit ALU.
// Decodes a MIPS instruction into an ALU op code and two operands, then holds
// them behind a valid/ready handshake with stall, flush and an issue counter.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [DW-1:0]    rs_data,
  input  logic [DW-1:0]    rt_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    alu_in1,
  output logic [DW-1:0]    alu_in2,
  output logic [2:0]       aluop,
  output logic [4:0]       wr_reg,
  output logic             reg_write,
  output logic             is_branch,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic [DW-1:0] shamt_zext;

  // The rs register index is resolved by the register file upstream.
  logic unused_rs_idx;

  logic          out_valid_reg;
  logic [DW-1:0] alu_in1_reg, alu_in1_next;
  logic [DW-1:0] alu_in2_reg, alu_in2_next;
  logic [2:0]    aluop_reg, aluop_next;
  logic [4:0]    wr_reg_reg, wr_reg_next;
  logic          reg_write_reg, reg_write_next;
  logic          is_branch_reg, is_branch_next;
  logic          illegal_reg, illegal_next;
  logic [CNT_W-1:0] issue_count_reg;
  logic          wr_en_raw;
  logic          load;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_rs_idx = ^instr[25:21];

  assign imm_sext[15:0]   = instr[15:0];
  assign imm_zext[15:0]   = instr[15:0];
  assign shamt_zext[4:0]  = instr[10:6];

  genvar gi;
  generate
    for (gi = 16; gi < DW; gi++) begin : g_imm_ext
      assign imm_sext[gi] = instr[15];
      assign imm_zext[gi] = 1'b0;
    end
    for (gi = 5; gi < DW; gi++) begin : g_shamt_ext
      assign shamt_zext[gi] = 1'b0;
    end
  endgenerate

  // A new instruction can enter when the slot is empty or being emptied now.
  assign in_ready = !rst && (!out_valid_reg || out_ready);
  assign load     = in_valid && in_ready && !flush;

  // Decode opcode/funct into ALU op, operands and writeback info.
  always_comb begin
    aluop_next     = ALU_ADD;
    alu_in1_next   = '0;
    alu_in2_next   = '0;
    wr_reg_next    = 5'd0;
    wr_en_raw      = 1'b0;
    is_branch_next = 1'b0;
    illegal_next   = 1'b0;
    case (opcode)
      6'h00: begin
        wr_reg_next  = instr[15:11];
        wr_en_raw    = 1'b1;
        alu_in1_next = rs_data;
        alu_in2_next = rt_data;
        case (funct)
          6'h20: aluop_next = ALU_ADD;
          6'h22: aluop_next = ALU_SUB;
          6'h24: aluop_next = ALU_AND;
          6'h25: aluop_next = ALU_OR;
          6'h2A: aluop_next = ALU_SLT;
          6'h00: begin
            aluop_next   = ALU_SLL;
            alu_in1_next = rt_data;
            alu_in2_next = shamt_zext;
          end
          6'h02: begin
            aluop_next   = ALU_SRL;
            alu_in1_next = rt_data;
            alu_in2_next = shamt_zext;
          end
          default: begin
            illegal_next = 1'b1;
            wr_reg_next  = 5'd0;
            wr_en_raw    = 1'b0;
            alu_in1_next = '0;
            alu_in2_next = '0;
          end
        endcase
      end
      6'h08: begin
        aluop_next = ALU_ADD; alu_in1_next = rs_data; alu_in2_next = imm_sext;
        wr_reg_next = instr[20:16]; wr_en_raw = 1'b1;
      end
      6'h0A: begin
        aluop_next = ALU_SLT; alu_in1_next = rs_data; alu_in2_next = imm_sext;
        wr_reg_next = instr[20:16]; wr_en_raw = 1'b1;
      end
      6'h0C: begin
        aluop_next = ALU_AND; alu_in1_next = rs_data; alu_in2_next = imm_zext;
        wr_reg_next = instr[20:16]; wr_en_raw = 1'b1;
      end
      6'h0D: begin
        aluop_next = ALU_OR; alu_in1_next = rs_data; alu_in2_next = imm_zext;
        wr_reg_next = instr[20:16]; wr_en_raw = 1'b1;
      end
      6'h04: begin
        aluop_next = ALU_SUB; alu_in1_next = rs_data; alu_in2_next = rt_data;
        is_branch_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded.
    reg_write_next = wr_en_raw && (wr_reg_next != 5'd0);
  end

  // Pipeline register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      alu_in1_reg   <= '0;
      alu_in2_reg   <= '0;
      aluop_reg     <= 3'd0;
      wr_reg_reg    <= 5'd0;
      reg_write_reg <= 1'b0;
      is_branch_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      alu_in1_reg   <= alu_in1_next;
      alu_in2_reg   <= alu_in2_next;
      aluop_reg     <= aluop_next;
      wr_reg_reg    <= wr_reg_next;
      reg_write_reg <= reg_write_next;
      is_branch_reg <= is_branch_next;
      illegal_reg   <= illegal_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Count instructions accepted downstream, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count_reg <= '0;
    end else if (out_valid_reg && out_ready && !flush && (issue_count_reg != '1)) begin
      issue_count_reg <= issue_count_reg + 1'b1;
    end
  end

  assign out_valid   = out_valid_reg;
  assign alu_in1     = alu_in1_reg;
  assign alu_in2     = alu_in2_reg;
  assign aluop       = aluop_reg;
  assign wr_reg      = wr_reg_reg;
  assign reg_write   = reg_write_reg;
  assign is_branch   = is_branch_reg;
  assign illegal     = illegal_reg;
  assign issue_count = issue_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of the decode/issue register.
// Issue counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_id_ex_stage;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [DW-1:0]    rs_data;
  logic [DW-1:0]    rt_data;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    alu_in1;
  logic [DW-1:0]    alu_in2;
  logic [2:0]       aluop;
  logic [4:0]       wr_reg;
  logic             reg_write;
  logic             is_branch;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .aluop(aluop), .wr_reg(wr_reg), .reg_write(reg_write),
    .is_branch(is_branch), .illegal(illegal), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = ins;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_count", {28'b0, issue_count}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // add $3,$1,$2
    drive(1'b1, 32'h00221820, 32'd10, 32'd5);
    step();
    $display("txn add");
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_aluop", {29'b0, aluop}, 32'd0);
    chk("add_in1", alu_in1, 32'd10);
    chk("add_in2", alu_in2, 32'd5);
    chk("add_wr_reg", {27'b0, wr_reg}, 32'd3);
    chk("add_reg_write", {31'b0, reg_write}, 32'd1);
    chk("add_count", {28'b0, issue_count}, 32'd0);

    // addi $4,$1,-1
    drive(1'b1, 32'h2024FFFF, 32'd7, 32'd0);
    step();
    $display("txn addi");
    chk("addi_count", {28'b0, issue_count}, 32'd1);
    chk("addi_aluop", {29'b0, aluop}, 32'd0);
    chk("addi_in1", alu_in1, 32'd7);
    chk("addi_in2", alu_in2, 32'hFFFFFFFF);
    chk("addi_wr_reg", {27'b0, wr_reg}, 32'd4);

    // ori $4,$1,0xFFFF
    drive(1'b1, 32'h3424FFFF, 32'd7, 32'd0);
    step();
    $display("txn ori");
    chk("ori_aluop", {29'b0, aluop}, 32'd3);
    chk("ori_in2", alu_in2, 32'h0000FFFF);
    chk("ori_count", {28'b0, issue_count}, 32'd2);

    // sll $5,$2,3
    drive(1'b1, 32'h000228C0, 32'd99, 32'd1);
    step();
    $display("txn sll");
    chk("sll_aluop", {29'b0, aluop}, 32'd4);
    chk("sll_in1", alu_in1, 32'd1);
    chk("sll_in2", alu_in2, 32'd3);
    chk("sll_wr_reg", {27'b0, wr_reg}, 32'd5);

    // beq $1,$2,4
    drive(1'b1, 32'h10220004, 32'd20, 32'd20);
    step();
    $display("txn beq");
    chk("beq_aluop", {29'b0, aluop}, 32'd1);
    chk("beq_branch", {31'b0, is_branch}, 32'd1);
    chk("beq_reg_write", {31'b0, reg_write}, 32'd0);
    chk("beq_wr_reg", {27'b0, wr_reg}, 32'd0);
    chk("beq_count", {28'b0, issue_count}, 32'd4);

    // Backpressure with sub $3,$1,$2 offered
    out_ready = 1'b0;
    drive(1'b1, 32'h00221822, 32'd9, 32'd4);
    #1;
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      $display("txn stall %0d", i);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_aluop", {29'b0, aluop}, 32'd1);
      chk("bp_in1", alu_in1, 32'd20);
      chk("bp_branch", {31'b0, is_branch}, 32'd1);
      chk("bp_count", {28'b0, issue_count}, 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    $display("txn sub");
    chk("sub_count", {28'b0, issue_count}, 32'd5);
    chk("sub_aluop", {29'b0, aluop}, 32'd1);
    chk("sub_in1", alu_in1, 32'd9);
    chk("sub_in2", alu_in2, 32'd4);
    chk("sub_branch", {31'b0, is_branch}, 32'd0);
    chk("sub_reg_write", {31'b0, reg_write}, 32'd1);

    // Flush with and $3,$1,$2 offered
    flush = 1'b1;
    drive(1'b1, 32'h00221824, 32'd1, 32'd2);
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    $display("txn flush");
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_count", {28'b0, issue_count}, 32'd5);
    chk("flush_in1_kept", alu_in1, 32'd9);

    // Illegal opcode 0x3F
    drive(1'b1, 32'hFC000000, 32'd11, 32'd12);
    step();
    $display("txn illegal");
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_reg_write", {31'b0, reg_write}, 32'd0);
    chk("ill_in1", alu_in1, 32'd0);
    chk("ill_wr_reg", {27'b0, wr_reg}, 32'd0);

    // Drain
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    $display("txn drain");
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_count", {28'b0, issue_count}, 32'd6);
    chk("drain_illegal_kept", {31'b0, illegal}, 32'd1);

    // addi $0,$1,5: destination $0 suppresses write
    drive(1'b1, 32'h20200005, 32'd3, 32'd0);
    step();
    $display("txn addi_r0");
    chk("r0_reg_write", {31'b0, reg_write}, 32'd0);
    chk("r0_in2", alu_in2, 32'd5);
    chk("r0_illegal", {31'b0, illegal}, 32'd0);

    // andi $4,$1,0x8000: zero extension
    drive(1'b1, 32'h30248000, 32'd3, 32'd0);
    step();
    $display("txn andi");
    chk("andi_aluop", {29'b0, aluop}, 32'd2);
    chk("andi_in2", alu_in2, 32'h00008000);
    chk("andi_reg_write", {31'b0, reg_write}, 32'd1);

    // slti $4,$1,0x8000: sign extension
    drive(1'b1, 32'h28248000, 32'd3, 32'd0);
    step();
    $display("txn slti");
    chk("slti_aluop", {29'b0, aluop}, 32'd6);
    chk("slti_in2", alu_in2, 32'hFFFF8000);
    chk("slti_count", {28'b0, issue_count}, 32'd8);

    // Unlisted R-type funct (0x3F)
    drive(1'b1, 32'h0022183F, 32'd3, 32'd4);
    step();
    $display("txn bad_funct");
    chk("badf_illegal", {31'b0, illegal}, 32'd1);
    chk("badf_in2", alu_in2, 32'd0);
    chk("badf_count", {28'b0, issue_count}, 32'd9);

    // Stream adds to saturate the narrow counter
    drive(1'b1, 32'h00221820, 32'd1, 32'd1);
    for (int i = 0; i < 10; i++) step();
    $display("txn saturate");
    chk("sat_count", {28'b0, issue_count}, 32'd15);
    step();
    chk("sat_count_hold", {28'b0, issue_count}, 32'd15);

    // Hold, then async reset between edges
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk("hold_valid", {31'b0, out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    $display("txn async_rst");
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_count", {28'b0, issue_count}, 32'd0);
    chk("arst_in1", alu_in1, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
